// File: rtl/trigger_event_buffer.sv
// Timestamps accepted trigger edges, applies a dead time after each one, and queues
// {timestamp, TOT_SHORT, TOT_LONG} events for the readout side to pop one at a time.
module trigger_event_buffer #(
    parameter int TS_WIDTH   = 32,
    parameter int DEPTH_LOG2 = 4,
    parameter int DEADTIME   = 8
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    ENABLE,
    input  logic                    TRIGGER_IN,
    input  logic [15:0]             TOT_SHORT,
    input  logic [15:0]             TOT_LONG,
    input  logic                    RD_REQ,
    input  logic                    CLEAR_DROPPED,
    output logic [TS_WIDTH+31:0]    RD_DATA,
    output logic                    RD_VALID,
    output logic                    EMPTY,
    output logic                    FULL,
    output logic [DEPTH_LOG2:0]     COUNT,
    output logic [15:0]             DROPPED,
    output logic                    BUSY
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int DW    = TS_WIDTH + 32;
    localparam int CNT_W = $clog2(DEADTIME + 1);
    localparam logic [CNT_W-1:0]      DEAD_INIT = CNT_W'(DEADTIME - 1);
    localparam logic [DEPTH_LOG2:0]   FULL_CNT  = (DEPTH_LOG2 + 1)'(DEPTH);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_DEAD = 1'b1} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       dead_q, dead_d;
    logic [TS_WIDTH-1:0]    ts_q;
    logic                   trig_q;
    logic [DW-1:0]          mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]  wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]    count_q, count_d;
    logic                   full_q, empty_q;
    logic [15:0]            dropped_q, dropped_d;
    logic [DW-1:0]          rd_data_q;
    logic                   rd_valid_q;
    logic                   busy_q;

    logic edge_s, accept_s, wr_en_s, drop_s, rd_en_s;

    assign edge_s   = TRIGGER_IN & ~trig_q;
    assign accept_s = (state_q == ST_IDLE) & edge_s & ENABLE;
    // Full/empty are the pre-cycle flags, so a pop never makes room for a same-cycle write.
    assign wr_en_s  = accept_s & ~full_q;
    assign drop_s   = accept_s & full_q;
    assign rd_en_s  = RD_REQ & ~empty_q;

    // Dead-time FSM: counter runs down once, then waits for the trigger level to fall.
    always_comb begin
        state_d = state_q;
        dead_d  = dead_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_DEAD;
                    dead_d  = DEAD_INIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DEAD: begin
                if (dead_q == {CNT_W{1'b0}}) begin
                    if (!TRIGGER_IN) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DEAD;
                    end
                end else begin
                    dead_d = dead_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                dead_d  = {CNT_W{1'b0}};
            end
        endcase
    end

    // Occupancy and drop-counter next state.
    always_comb begin
        count_d = count_q;
        case ({wr_en_s, rd_en_s})
            2'b10:   count_d = count_q + (DEPTH_LOG2 + 1)'(1);
            2'b01:   count_d = count_q - (DEPTH_LOG2 + 1)'(1);
            default: count_d = count_q;
        endcase
        dropped_d = dropped_q;
        if (CLEAR_DROPPED) begin
            dropped_d = 16'h0000;
        end else if (drop_s && (dropped_q != 16'hFFFF)) begin
            dropped_d = dropped_q + 16'h0001;
        end else begin
            dropped_d = dropped_q;
        end
    end

    // Control, status and read-port registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            dead_q     <= {CNT_W{1'b0}};
            ts_q       <= {TS_WIDTH{1'b0}};
            trig_q     <= 1'b0;
            wr_ptr_q   <= {DEPTH_LOG2{1'b0}};
            rd_ptr_q   <= {DEPTH_LOG2{1'b0}};
            count_q    <= {(DEPTH_LOG2 + 1){1'b0}};
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            dropped_q  <= 16'h0000;
            rd_data_q  <= {DW{1'b0}};
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dead_q     <= dead_d;
            ts_q       <= ts_q + TS_WIDTH'(1);
            trig_q     <= TRIGGER_IN;
            count_q    <= count_d;
            full_q     <= (count_d == FULL_CNT);
            empty_q    <= (count_d == {(DEPTH_LOG2 + 1){1'b0}});
            dropped_q  <= dropped_d;
            rd_valid_q <= rd_en_s;
            busy_q     <= (state_d == ST_DEAD);
            if (wr_en_s) begin
                wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
            end
            if (rd_en_s) begin
                rd_ptr_q  <= rd_ptr_q + DEPTH_LOG2'(1);
                rd_data_q <= mem_q[rd_ptr_q];
            end
        end
    end

    // Event storage; contents are don't-care after reset since the pointers restart.
    always_ff @(posedge CLK) begin
        if (wr_en_s && !RESET) begin
            mem_q[wr_ptr_q] <= {ts_q, TOT_SHORT, TOT_LONG};
        end
    end

    assign RD_DATA  = rd_data_q;
    assign RD_VALID = rd_valid_q;
    assign EMPTY    = empty_q;
    assign FULL     = full_q;
    assign COUNT    = count_q;
    assign DROPPED  = dropped_q;
    assign BUSY     = busy_q;

endmodule

// File: tb/tb_trigger_event_buffer.sv
// Scoreboard bench for trigger_event_buffer: a queue-based reference model predicts every
// output; a monitor compares on each falling edge and pops expected read data on RD_VALID.
module tb_trigger_event_buffer;

    localparam int DT = 8;

    logic        CLK = 1'b0;
    logic        RESET, ENABLE, TRIGGER_IN, RD_REQ, CLEAR_DROPPED;
    logic [15:0] TOT_SHORT, TOT_LONG;
    logic [63:0] RD_DATA;
    logic        RD_VALID, EMPTY, FULL, BUSY;
    logic [4:0]  COUNT;
    logic [15:0] DROPPED;

    // Small-timestamp instance used to exercise counter wrap in reasonable time.
    logic        w_reset, w_trig, w_rd;
    logic [36:0] w_rd_data;
    logic        w_valid, w_empty, w_full, w_busy;
    logic [2:0]  w_count;
    logic [15:0] w_dropped;

    always #5 CLK = ~CLK;

    trigger_event_buffer u_dut (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .TRIGGER_IN(TRIGGER_IN),
        .TOT_SHORT(TOT_SHORT), .TOT_LONG(TOT_LONG), .RD_REQ(RD_REQ),
        .CLEAR_DROPPED(CLEAR_DROPPED), .RD_DATA(RD_DATA), .RD_VALID(RD_VALID),
        .EMPTY(EMPTY), .FULL(FULL), .COUNT(COUNT), .DROPPED(DROPPED), .BUSY(BUSY)
    );

    trigger_event_buffer #(.TS_WIDTH(5), .DEPTH_LOG2(2), .DEADTIME(3)) u_wrap (
        .CLK(CLK), .RESET(w_reset), .ENABLE(1'b1), .TRIGGER_IN(w_trig),
        .TOT_SHORT(16'hAAAA), .TOT_LONG(16'h5555), .RD_REQ(w_rd),
        .CLEAR_DROPPED(1'b0), .RD_DATA(w_rd_data), .RD_VALID(w_valid),
        .EMPTY(w_empty), .FULL(w_full), .COUNT(w_count), .DROPPED(w_dropped), .BUSY(w_busy)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s wait bound expired t=%0t", name, $time);
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_ts;
    logic        m_trig_prev;
    bit          m_dead;
    longint      m_cyc, m_acc_cyc;
    logic [63:0] m_fifo[$];
    logic [15:0] m_dropped;
    logic [63:0] m_rd_data;
    bit          m_valid;
    logic [63:0] sb[$];
    logic [4:0]  w_ts;

    // Reference model: events are a queue, dead time is "cycles since acceptance".
    always @(posedge CLK) begin
        bit edge_v, full_v, empty_v, accept_v;
        if (RESET) begin
            m_ts = 32'd0; m_trig_prev = 1'b0; m_dead = 0; m_cyc = 0; m_acc_cyc = 0;
            m_fifo.delete(); sb.delete();
            m_dropped = 16'd0; m_rd_data = 64'd0; m_valid = 0;
        end else begin
            m_valid  = 0;
            edge_v   = TRIGGER_IN && !m_trig_prev;
            full_v   = (m_fifo.size() == 16);
            empty_v  = (m_fifo.size() == 0);
            accept_v = !m_dead && edge_v && ENABLE;
            if (RD_REQ && !empty_v) begin
                m_rd_data = m_fifo.pop_front();
                sb.push_back(m_rd_data);
                m_valid = 1;
            end
            if (accept_v && !full_v) m_fifo.push_back({m_ts, TOT_SHORT, TOT_LONG});
            if (CLEAR_DROPPED) m_dropped = 16'd0;
            else if (accept_v && full_v && m_dropped != 16'hFFFF) m_dropped++;
            if (accept_v) begin
                m_dead = 1; m_acc_cyc = m_cyc;
            end else if (m_dead && (m_cyc - m_acc_cyc >= DT) && !TRIGGER_IN) begin
                m_dead = 0;
            end
            m_ts++;
            m_cyc++;
            m_trig_prev = TRIGGER_IN;
        end
        w_ts = w_reset ? 5'd0 : w_ts + 5'd1;
    end

    // Monitor: compare every output away from the active edge.
    always @(negedge CLK) begin
        check("rd_valid", RD_VALID, m_valid);
        if (RD_VALID === 1'b1) begin
            if (sb.size() == 0) timeout("rd_unexpected_no_sb_entry");
            else check("rd_data_sb", RD_DATA, sb.pop_front());
        end
        check("rd_data_hold", RD_DATA, m_rd_data);
        check("count", COUNT, m_fifo.size());
        check("empty", EMPTY, m_fifo.size() == 0);
        check("full", FULL, m_fifo.size() == 16);
        check("dropped", DROPPED, m_dropped);
        check("busy", BUSY, m_dead);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic wait_ts(input logic [31:0] v);
        int n = 0;
        while (m_ts != v && n < 2000) begin tick(); n++; end
        if (n >= 2000) timeout("wait_ts");
    endtask

    task automatic wait_wts(input logic [4:0] v);
        int n = 0;
        while (w_ts != v && n < 100) begin tick(); n++; end
        if (n >= 100) timeout("wait_wts");
    endtask

    task automatic pulse1();
        TOT_SHORT = 16'($urandom); TOT_LONG = 16'($urandom);
        TRIGGER_IN = 1'b1; tick(); TRIGGER_IN = 1'b0;
    endtask

    task automatic spaced_edges(input int n);
        for (int i = 0; i < n; i++) begin pulse1(); repeat (11) tick(); end
    endtask

    task automatic read1();
        RD_REQ = 1'b1; tick(); RD_REQ = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (m_fifo.size() != 0 && n < 40) begin read1(); tick(); n++; end
        if (n >= 40) timeout("drain");
    endtask

    initial begin
        logic [36:0] w_exp;
        int rd_div;
        RESET = 1'b1; w_reset = 1'b1; ENABLE = 1'b0; TRIGGER_IN = 1'b0; RD_REQ = 1'b0;
        CLEAR_DROPPED = 1'b0; TOT_SHORT = 16'd0; TOT_LONG = 16'd0; w_trig = 1'b0; w_rd = 1'b0;
        tick();
        check("rst_count", COUNT, 5'd0);    check("rst_empty", EMPTY, 1'b1);
        check("rst_full", FULL, 1'b0);      check("rst_busy", BUSY, 1'b0);
        check("rst_rd_data", RD_DATA, 64'd0); check("rst_dropped", DROPPED, 16'd0);
        tick();
        RESET = 1'b0; w_reset = 1'b0; ENABLE = 1'b1;

        // basic capture
        TOT_SHORT = 16'h0012; TOT_LONG = 16'h0034;
        wait_ts(32'd100);
        TRIGGER_IN = 1'b1; tick();
        check("basic_count1", COUNT, 5'd1); check("basic_busy1", BUSY, 1'b1);
        tick(); tick(); TRIGGER_IN = 1'b0;
        repeat (5) tick();
        check("basic_busy_last", BUSY, 1'b1);
        tick();
        check("basic_busy_drop", BUSY, 1'b0);
        repeat (3) tick();
        read1();
        check("basic_rd_valid", RD_VALID, 1'b1);
        check("basic_rd_data", RD_DATA, 64'h00000064_0012_0034);
        check("basic_count0", COUNT, 5'd0); check("basic_empty", EMPTY, 1'b1);

        // dead time
        wait_ts(32'd200); pulse1();
        wait_ts(32'd203); pulse1();
        wait_ts(32'd210); pulse1();
        repeat (12) tick();
        check("dead_count2", COUNT, 5'd2); check("dead_dropped0", DROPPED, 16'd0);
        TRIGGER_IN = 1'b1; repeat (20) tick();
        TRIGGER_IN = 1'b0;
        check("held_busy", BUSY, 1'b1);
        tick();
        check("held_busy_drop", BUSY, 1'b0);
        repeat (10) tick();

        // overflow
        drain();
        spaced_edges(18);
        check("ovf_full", FULL, 1'b1); check("ovf_count", COUNT, 5'd16);
        check("ovf_dropped", DROPPED, 16'd2);
        for (int i = 0; i < 16; i++) begin read1(); tick(); end
        check("ovf_empty", EMPTY, 1'b1);
        CLEAR_DROPPED = 1'b1; tick(); CLEAR_DROPPED = 1'b0;
        check("clr_dropped", DROPPED, 16'd0);

        // simultaneous read and write
        spaced_edges(3);
        TRIGGER_IN = 1'b1; RD_REQ = 1'b1; tick(); TRIGGER_IN = 1'b0; RD_REQ = 1'b0;
        check("simul_count3", COUNT, 5'd3); check("simul_valid", RD_VALID, 1'b1);
        repeat (11) tick();
        spaced_edges(13);
        check("simul_full", FULL, 1'b1);
        TRIGGER_IN = 1'b1; RD_REQ = 1'b1; tick(); TRIGGER_IN = 1'b0; RD_REQ = 1'b0;
        check("simul_full_dropped", DROPPED, 16'd1); check("simul_full_count", COUNT, 5'd15);
        repeat (11) tick();
        drain();

        // empty read and disabled triggers
        read1();
        check("empty_rd_valid", RD_VALID, 1'b0);
        CLEAR_DROPPED = 1'b1; tick(); CLEAR_DROPPED = 1'b0;
        ENABLE = 1'b0;
        for (int i = 0; i < 5; i++) begin pulse1(); tick(); tick(); end
        check("dis_count", COUNT, 5'd0); check("dis_dropped", DROPPED, 16'd0);
        check("dis_busy", BUSY, 1'b0);
        ENABLE = 1'b1;

        // reset mid dead time
        spaced_edges(4);
        pulse1();
        check("mid_count5", COUNT, 5'd5); check("mid_busy", BUSY, 1'b1);
        RESET = 1'b1; tick(); RESET = 1'b0;
        check("mid_rst_count", COUNT, 5'd0); check("mid_rst_empty", EMPTY, 1'b1);
        check("mid_rst_busy", BUSY, 1'b0);   check("mid_rst_dropped", DROPPED, 16'd0);
        pulse1(); tick(); tick();
        read1();
        check("mid_rst_ts0", RD_DATA[63:32], 32'd0);
        repeat (10) tick();

        // randomized traffic: slow reads first to provoke overflow, then fast reads
        for (int i = 0; i < 3000; i++) begin
            rd_div = (i < 1500) ? 16 : 3;
            if ($urandom_range(0, 3) == 0) TRIGGER_IN = ~TRIGGER_IN;
            RD_REQ        = ($urandom_range(0, rd_div - 1) == 0);
            ENABLE        = ($urandom_range(0, 9) != 0);
            CLEAR_DROPPED = ($urandom_range(0, 49) == 0);
            RESET         = ($urandom_range(0, 999) == 0);
            TOT_SHORT     = 16'($urandom);
            TOT_LONG      = 16'($urandom);
            tick();
        end
        TRIGGER_IN = 1'b0; RD_REQ = 1'b0; CLEAR_DROPPED = 1'b0; RESET = 1'b0; ENABLE = 1'b1;
        repeat (12) tick();
        drain();

        // timestamp wrap on the narrow instance
        wait_wts(5'd30);
        w_trig = 1'b1; tick(); w_trig = 1'b0;
        wait_wts(5'd8);
        w_trig = 1'b1; tick(); w_trig = 1'b0;
        repeat (5) tick();
        w_rd = 1'b1; tick(); w_rd = 1'b0;
        w_exp = {5'd30, 16'hAAAA, 16'h5555};
        check("wrap_valid1", w_valid, 1'b1); check("wrap_data1", w_rd_data, w_exp);
        w_rd = 1'b1; tick(); w_rd = 1'b0;
        w_exp = {5'd8, 16'hAAAA, 16'h5555};
        check("wrap_valid2", w_valid, 1'b1); check("wrap_data2", w_rd_data, w_exp);
        check("wrap_empty", w_empty, 1'b1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/trigger_event_buffer.md
Name: trigger_event_buffer

Overview:
- Consumer end of the trigger chain. Takes the combined trigger from the trigger handler plus the short-window and long-window TOT values, and timestamps each accepted trigger.
- Stores {timestamp, TOT_SHORT, TOT_LONG} events in a FIFO that the readout side drains with a request/valid handshake.
- Applies a programmable dead time after each accepted trigger.
- Runs on CLK_FAST alongside the trigger logic.

Parameters:
- TS_WIDTH, 32, width of the free-running timestamp counter.
- DEPTH_LOG2, 4, FIFO depth is 2**DEPTH_LOG2 events (16).
- DEADTIME, 8, minimum cycles in DEAD after an accepted trigger; must be ≥ 1.

Ports:
- CLK  in  1  clock (CLK_FAST domain)
- RESET  in  1  synchronous active-high reset
- ENABLE  in  1  1 = accept triggers; 0 = ignore edges (reads still serviced)
- TRIGGER_IN  in  1  combined trigger level (TRIGGER_OUT of trigger handler)
- TOT_SHORT  in  16  short-window TOT value
- TOT_LONG  in  16  long-window TOT value
- RD_REQ  in  1  one-cycle pop request from readout
- CLEAR_DROPPED  in  1  zero the DROPPED counter
- RD_DATA  out  TS_WIDTH+32  {timestamp, TOT_SHORT, TOT_LONG} of popped event
- RD_VALID  out  1  RD_DATA valid, one-cycle pulse
- EMPTY  out  1  FIFO empty
- FULL  out  1  FIFO full
- COUNT  out  DEPTH_LOG2+1  events stored, 0..16
- DROPPED  out  16  accepted-edge triggers lost because FIFO full; saturates at 65535
- BUSY  out  1  high while in DEAD state

Behaviour:
- Reset values:
  - RD_DATA=0, RD_VALID=0, EMPTY=1, FULL=0, COUNT=0, DROPPED=0, BUSY=0.
  - Timestamp=0, FIFO pointers=0, trig_d=0, state=IDLE.
- Reset at any point, including mid-dead-time or mid-read, empties the FIFO. No partial event survives.
- Timestamp: increments every cycle and wraps from 2**TS_WIDTH-1 to 0. It is not gated by ENABLE.
- Edge detect:
  - trig_d is TRIGGER_IN registered.
  - edge = TRIGGER_IN & ~trig_d in cycle N.
  - The captured event uses the timestamp register value and the TOT_SHORT/TOT_LONG input values of cycle N.
- FSM, state IDLE:
  - If edge & ENABLE: the edge is accepted.
  - If FULL is 0 in cycle N, write the event and COUNT increments in N+1.
  - If FULL is 1 in cycle N, drop the event; DROPPED increments in N+1, saturating.
  - Either way, go to DEAD and load the dead counter with DEADTIME-1.
- FSM, state DEAD:
  - BUSY=1.
  - The dead counter decrements to 0, then holds.
  - Return to IDLE on the first cycle where dead counter == 0 and TRIGGER_IN == 0.
  - Edges seen in DEAD are ignored and are not counted.
- ENABLE=0 in IDLE: edges are ignored. ENABLE=0 in DEAD: the state still completes its dead time.
- Read handshake:
  - RD_REQ in cycle M with EMPTY=0 pops the oldest event.
  - In M+1: RD_DATA = that event, RD_VALID=1, COUNT decremented.
  - RD_REQ with EMPTY=1 is ignored: RD_VALID stays 0 and RD_DATA holds its last value.
  - RD_DATA holds between reads.
- Simultaneous write and read in the same cycle:
  - Both occur and COUNT is unchanged.
  - The full check uses the pre-cycle FULL, so a write arriving while FULL=1 is dropped even if RD_REQ pops in the same cycle.
  - A read from an empty FIFO in the same cycle as a write returns nothing (EMPTY was 1). The written event is available from the next cycle.
- Status flags: FULL = (COUNT==16) and EMPTY = (COUNT==0). Both are registered and consistent with COUNT in every cycle.
- Pointers are DEPTH_LOG2 bits wide and wrap modulo 16.
- CLEAR_DROPPED zeroes DROPPED next cycle. If a drop happens in the same cycle, CLEAR_DROPPED takes priority and the result is 0.
- Storage is registers or one BRAM. Read latency is fixed at 1 cycle either way.

Test Plan:
- Basic capture:
  - Stimulus: RESET 2 cycles; ENABLE=1; TOT_SHORT=0x0012, TOT_LONG=0x0034; TRIGGER_IN rises with timestamp=100, held 3 cycles; RD_REQ pulse.
  - Response: COUNT=1 and BUSY=1 the cycle after the edge; BUSY drops 8 cycles after the edge; RD_VALID=1 one cycle after RD_REQ with RD_DATA={32'd100,16'h0012,16'h0034}; COUNT=0, EMPTY=1.
- Dead time:
  - Stimulus: edges at timestamps 200, 203 and 210, each one cycle high.
  - Response: only the events at 200 and 210 are stored; COUNT=2; DROPPED=0.
  - Stimulus: TRIGGER_IN held high for 20 cycles.
  - Response: BUSY stays high until the cycle after TRIGGER_IN falls.
- Overflow:
  - Stimulus: 18 spaced edges (≥10 cycles apart) with no reads.
  - Response: FULL=1 after the 16th edge; COUNT=16; DROPPED=2; 16 reads return the first 16 timestamps in order, then EMPTY=1.
  - Stimulus: CLEAR_DROPPED pulse.
  - Response: DROPPED=0.
- Simultaneous read/write:
  - Stimulus: COUNT=3; RD_REQ in the same cycle as an accepted edge.
  - Response: COUNT stays 3 and the oldest event is returned.
  - Stimulus: FULL; RD_REQ together with an edge.
  - Response: DROPPED+1; COUNT=15 next cycle.
- Empty read and enable:
  - Stimulus: RD_REQ with EMPTY=1.
  - Response: RD_VALID=0; RD_DATA unchanged.
  - Stimulus: ENABLE=0; 5 edges.
  - Response: COUNT=0, DROPPED=0, BUSY=0.
- Reset mid-operation and wrap:
  - Stimulus: COUNT=5, BUSY=1; RESET for 1 cycle.
  - Response: COUNT=0, EMPTY=1, BUSY=0, DROPPED=0, timestamp restarts at 0.
  - Stimulus: force the timestamp to 0xFFFFFFFE; edges at 0xFFFFFFFE and 0x00000008.
  - Response: both stored in order with the correct wrapped timestamps.
